// File: rtl/mux_scan_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mux_scan_sequencer : steps a 4:1 mux select, waits a settle time, samples |
// | each channel and publishes the 4-bit word. Option: MUX_SCAN_PARITY_EN.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mux_scan_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned CNT_W         = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic       cont_i,
  input  logic       y_in_i,
  output logic [1:0] sel_o,
  output logic       busy_o,
  output logic       done_o,
  output logic [3:0] data_o,
`ifdef MUX_SCAN_PARITY_EN
  output logic       parity_o,
`endif
  output logic       changed_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] c_CNT_LAST =
    (SETTLE_CYCLES == 0) ? '0 : CNT_W'(SETTLE_CYCLES - 1);
  localparam state_t c_SCAN_ENTRY = (SETTLE_CYCLES == 0) ? S_SAMPLE : S_SETTLE;

  if ((SETTLE_CYCLES > 15) || (SETTLE_CYCLES > ((2 ** CNT_W) - 1))) begin : g_cnt_too_narrow
    $error("mux_scan_sequencer: SETTLE_CYCLES does not fit the settle counter");
  end

  state_t           state_q;
  logic [1:0]       sel_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       shadow_q;
  logic [3:0]       data_q;
  logic             busy_q;
  logic             done_q;
  logic             changed_q;
  logic [3:0]       scan_word_d;

  // The last channel bit goes straight into the published word on the same edge.
  assign scan_word_d = {y_in_i, shadow_q};

`ifdef MUX_SCAN_PARITY_EN
  logic parity_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else if ((state_q == S_SAMPLE) && (sel_q == 2'd3)) begin
      parity_q <= ^scan_word_d;
    end
  end
  assign parity_o = parity_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      sel_q     <= 2'd0;
      cnt_q     <= '0;
      shadow_q  <= 3'd0;
      data_q    <= 4'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      changed_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start_i) begin
            sel_q   <= 2'd0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= c_SCAN_ENTRY;
          end
        end
        S_SETTLE: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == c_CNT_LAST) begin
            state_q <= S_SAMPLE;
          end
        end
        S_SAMPLE: begin
          if (sel_q != 2'd3) begin
            shadow_q[sel_q] <= y_in_i;
            sel_q           <= sel_q + 2'd1;
            cnt_q           <= '0;
            state_q         <= c_SCAN_ENTRY;
          end else begin
            data_q    <= scan_word_d;
            changed_q <= (scan_word_d != data_q);
            done_q    <= 1'b1;
            state_q   <= S_DONE;
          end
        end
        S_DONE: begin
          sel_q <= 2'd0;
          cnt_q <= '0;
          if (cont_i) begin
            state_q <= c_SCAN_ENTRY;
          end else begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign sel_o     = sel_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign data_o    = data_q;
  assign changed_o = changed_q;

endmodule
`default_nettype wire

// File: doc/mux_scan_sequencer.md
Name: mux_scan_sequencer

Overview:
- Upstream controller for the 4:1 channel mux. Drives the 2-bit select, waits a programmable settle time, samples the mux output, and assembles all four channel values into a 4-bit word.
- Supports single-shot and continuous scanning, a one-cycle completion pulse, and change detection between consecutive scans.

Parameters:
- SETTLE_CYCLES, 2, number of cycles select is held stable before sampling; legal range 0..15; 0 bypasses SETTLE.
- CNT_W, 4, settle counter width; must hold SETTLE_CYCLES.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin a scan; sampled only in IDLE.
- cont  input  1  continuous mode; sampled in DONE.
- y_in  input  1  mux output, i.e. the selected channel bit.
- sel  output  2  mux select, channel currently addressed.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse; data is valid and updated.
- data  output  4  last completed scan; data[k] = channel k.
- changed  output  1  one-cycle pulse with done when the new data differs from the previous data.

Behaviour:
- Reset values, applied asynchronously and held while rst=1: state=IDLE, sel=0, busy=0, done=0, data=0, changed=0, shadow=0, counter=0.
- States are IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - start=1 → sel<=0, counter<=0.
  - Next state is SETTLE, or SAMPLE if SETTLE_CYCLES=0.
  - start=0 → remain in IDLE.
- SETTLE:
  - Counter increments each cycle.
  - Leave for SAMPLE on the cycle the counter reaches SETTLE_CYCLES-1, so SETTLE lasts exactly SETTLE_CYCLES cycles.
  - sel is held constant.
- SAMPLE (1 cycle): shadow[sel] <= y_in.
  - sel<3 → sel<=sel+1, counter<=0, next state SETTLE (or SAMPLE if SETTLE_CYCLES=0).
  - sel=3 → next state DONE, on the same edge:
    - data <= {y_in, shadow[2:0]}
    - changed <= ({y_in, shadow[2:0]} != data)
    - done <= 1
- DONE (1 cycle): done=1 and changed are visible for exactly this cycle.
  - cont=1 → sel<=0, counter<=0, next state SETTLE/SAMPLE with no idle gap.
  - cont=0 → IDLE, sel<=0.
- Latency: done is asserted for the cycle following edge 4*(SETTLE_CYCLES+1) after the edge that sampled start. SETTLE_CYCLES=2 gives 12 edges.
- Continuous scan period: 4*(SETTLE_CYCLES+1)+1 cycles.
- start while busy=1 is ignored, with no queuing.
- cont is sampled only in DONE, so changing it mid-scan affects only the end of the current scan.
- sel changes only on the edge leaving SAMPLE or DONE, never during SETTLE.
- The first scan after reset compares against data=0, so changed=1 iff the result is nonzero.
- data holds its value between done pulses and is never partially updated.
- Reset mid-scan: immediate return to reset values, partial shadow is discarded, and no done is produced.
- Counter width: the synthesis/elaboration check fails if SETTLE_CYCLES > 2^CNT_W - 1.

Optional Feature:
- Macro: MUX_SCAN_PARITY_EN.
- Defined:
  - Adds output port parity (1 bit, reset 0), registered on the same edge as data, equal to XOR of the new data.
  - Odd number of ones → 1.
- Undefined: no parity port and no parity logic; all other behaviour is identical.

Test Plan:
- Reset, then idle for 5 cycles with start=0 → sel=0, busy=0, done=0, data=4'b0000 throughout.
- SETTLE_CYCLES=2, channels I=4'b1010 drive y_in via the mux model, start pulse, cont=0:
  - sel steps 0,1,2,3, each held 3 cycles.
  - done and changed pulse once at edge 12; data=4'b1010.
  - busy drops the next cycle.
- Repeat the same scan with I unchanged → done pulses, changed=0, data=4'b1010.
- Then set I=4'b0101 and start → changed=1, data=4'b0101.
- cont=1 with I=4'b1111 → done pulses every 13 cycles.
  - First done has changed=1.
  - Subsequent pulses have changed=0.
  - sel never idles.
- Assert rst during SAMPLE of channel 2 → all outputs 0 immediately, no done.
- After release, a start with I=4'b0011 → data=4'b0011.
- SETTLE_CYCLES=0 build, I=4'b1001 → done at edge 4, data=4'b1001.
- With MUX_SCAN_PARITY_EN, I=4'b0111 → parity=1 with done.
